// File: rtl/fifo_uart_tx.sv
// UART transmit stage draining a byte FIFO: reads one byte per frame and shifts
// it out as start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic       fifo_wr_en,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);
    localparam logic           ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic bit_end;
    logic read_ok;

    assign bit_end = (cnt_q == BIT_LAST);
    // The FIFO services a write before a read, so a non-full write in the
    // READ cycle means our read strobe was ignored.
    assign read_ok = !fifo_empty && !(fifo_wr_en && !fifo_full);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = read_ok ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                shift_d = fifo_dout;
                par_d   = (^fifo_dout) ^ ODD;
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next-state values so they line up
        // with the state they belong to.
        rd_en_d = (state_d == S_READ);
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (cnt_d == BIT_LAST) && (stop_d == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no/even/odd parity, 4 clks per bit)
// each fed by a write-priority 16-deep FIFO model, with a frame decoder per line.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] f_wr, f_rd, f_empty, f_full, tx_w, busy_w, done_w;
    logic [7:0] f_wdata [3];
    logic [7:0] f_dout [3];
    logic [7:0] fmem [3][16];
    logic [4:0] fcnt [3];
    logic [3:0] frp [3];
    logic [3:0] fwp [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fifo_uart_tx #(
            .CLKS_PER_BIT(4),
            .PARITY(g),
            .STOP_BITS(1)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .fifo_empty(f_empty[g]),
            .fifo_full(f_full[g]),
            .fifo_wr_en(f_wr[g]),
            .fifo_dout(f_dout[g]),
            .fifo_rd_en(f_rd[g]),
            .tx(tx_w[g]),
            .busy(busy_w[g]),
            .tx_done(done_w[g])
        );
    end

    // FIFO model: a non-full write wins over a read in the same cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            f_empty[i] = (fcnt[i] == 5'd0);
            f_full[i]  = (fcnt[i] == 5'd16);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                fcnt[i]   <= '0;
                frp[i]    <= '0;
                fwp[i]    <= '0;
                f_dout[i] <= '0;
            end else if (f_wr[i] && !f_full[i]) begin
                fmem[i][fwp[i]] <= f_wdata[i];
                fwp[i]          <= fwp[i] + 4'd1;
                fcnt[i]         <= fcnt[i] + 5'd1;
            end else if (f_rd[i] && !f_empty[i]) begin
                f_dout[i] <= fmem[i][frp[i]];
                frp[i]    <= frp[i] + 4'd1;
                fcnt[i]   <= fcnt[i] - 5'd1;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
        end
    endtask

    // Expected frames as {stop, [parity,] data[7:0], start}, bit 0 sent first.
    logic [10:0] exp_q0[$];
    logic [10:0] exp_q1[$];
    logic [10:0] exp_q2[$];

    bit          in_f [3];
    int          fc [3];
    logic [10:0] got [3];
    bit          glitch [3];
    int          done_at [3];
    int          frames [3];
    int          starts [3];
    int          aborts [3];
    int          done_cnt [3];
    int          rd_cnt [3];
    int          start_log [3][64];
    int          end_log [3][64];

    function automatic int frame_len(input int i);
        return (i == 0) ? 40 : 44;
    endfunction

    // Frame decoder: samples every line on the falling edge.
    initial begin
        logic [10:0] e;
        bit          have;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (f_rd[i] === 1'b1) rd_cnt[i]++;
                if (done_w[i] === 1'b1) done_cnt[i]++;
                if (!in_f[i] && tx_w[i] === 1'b0) begin
                    in_f[i]    = 1'b1;
                    fc[i]      = 0;
                    got[i]     = '0;
                    glitch[i]  = 1'b0;
                    done_at[i] = -1;
                    if (starts[i] < 64) start_log[i][starts[i]] = cyc;
                    starts[i]++;
                end
                if (in_f[i]) begin
                    if (busy_w[i] !== 1'b1) begin
                        in_f[i] = 1'b0;
                        aborts[i]++;
                    end else begin
                        if (fc[i] % 4 == 0) got[i][fc[i] / 4] = tx_w[i];
                        else if (tx_w[i] !== got[i][fc[i] / 4]) glitch[i] = 1'b1;
                        if (done_w[i] === 1'b1 && done_at[i] < 0) done_at[i] = fc[i];
                        if (fc[i] == frame_len(i) - 1) begin
                            in_f[i] = 1'b0;
                            if (frames[i] < 64) end_log[i][frames[i]] = cyc;
                            frames[i]++;
                            have = 1'b0;
                            e    = '0;
                            case (i)
                                0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                                1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                                default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
                            endcase
                            check($sformatf("frame_expected[%0d]", i), have, 1);
                            if (have) begin
                                check($sformatf("frame_bits[%0d]", i), got[i], e);
                                check($sformatf("bit_stable[%0d]", i), glitch[i], 0);
                                check($sformatf("frame_len[%0d]", i), done_at[i] + 1, frame_len(i));
                            end
                        end else begin
                            fc[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic put(input int i, input logic [7:0] d);
        @(negedge clk);
        f_wr[i]    = 1'b1;
        f_wdata[i] = d;
    endtask

    task automatic idle_wr(input int i);
        @(negedge clk);
        f_wr[i] = 1'b0;
    endtask

    task automatic wait_frames(input int i, input int target, input int budget);
        int n = 0;
        while (frames[i] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("frame_wait[%0d]", i), frames[i] >= target, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cyc, fb, s, rb, db, ab;
        bit idle_bad;

        reset = 1'b1;
        f_wr  = '0;
        for (int i = 0; i < 3; i++) f_wdata[i] = '0;
        repeat (3) @(negedge clk);

        // Reset values while held in reset
        check("reset_tx", tx_w, 3'b111);
        check("reset_busy", busy_w, 3'b000);
        check("reset_rd", f_rd, 3'b000);
        check("reset_done", done_w, 3'b000);
        reset = 1'b0;

        // Idle with an empty FIFO
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_tx", tx_w[0], 1);
            check("idle_busy", busy_w[0], 0);
            check("idle_rd", f_rd[0], 0);
        end

        // Single byte 0xA5
        fb = frames[0]; s = starts[0]; rb = rd_cnt[0]; db = done_cnt[0];
        exp_q0.push_back(11'b0_1_1010_0101_0);
        put(0, 8'hA5);
        idle_wr(0);
        wr_cyc = cyc;
        wait_frames(0, fb + 1, 200);
        check("a5_latency", start_log[0][s] - wr_cyc, 3);
        repeat (2) @(negedge clk);
        check("a5_rd_pulses", rd_cnt[0] - rb, 1);
        check("a5_done_pulses", done_cnt[0] - db, 1);
        check("a5_fifo_empty", fcnt[0], 0);
        check("a5_busy_after", busy_w[0], 0);

        // Three bytes back-to-back
        fb = frames[0]; rb = rd_cnt[0];
        exp_q0.push_back(11'b0_1_0000_0001_0);
        exp_q0.push_back(11'b0_1_0000_0010_0);
        exp_q0.push_back(11'b0_1_0000_0011_0);
        put(0, 8'h01);
        put(0, 8'h02);
        idle_wr(0);
        put(0, 8'h03);
        idle_wr(0);
        wait_frames(0, fb + 3, 400);
        check("b2b_gap1", start_log[0][fb + 1] - end_log[0][fb] - 1, 3);
        check("b2b_gap2", start_log[0][fb + 2] - end_log[0][fb + 1] - 1, 3);
        repeat (2) @(negedge clk);
        check("b2b_rd_pulses", rd_cnt[0] - rb, 3);
        check("b2b_fifo_empty", fcnt[0], 0);

        // 0x07 with even and odd parity
        exp_q1.push_back(11'b1_1_0000_0111_0);
        exp_q2.push_back(11'b1_0_0000_0111_0);
        @(negedge clk);
        f_wr[1] = 1'b1; f_wdata[1] = 8'h07;
        f_wr[2] = 1'b1; f_wdata[2] = 8'h07;
        @(negedge clk);
        f_wr[1] = 1'b0;
        f_wr[2] = 1'b0;
        wait_frames(1, 1, 200);
        wait_frames(2, 1, 200);
        repeat (2) @(negedge clk);
        check("par_even_rd", rd_cnt[1], 1);
        check("par_odd_rd", rd_cnt[2], 1);

        // Write collides with the READ cycle: read dropped and retried
        fb = frames[0]; s = starts[0]; rb = rd_cnt[0];
        exp_q0.push_back(11'b0_1_0001_0001_0);
        exp_q0.push_back(11'b0_1_0010_0010_0);
        put(0, 8'h11);
        idle_wr(0);
        wr_cyc = cyc;
        put(0, 8'h22);
        idle_wr(0);
        wait_frames(0, fb + 2, 300);
        check("drop_latency", start_log[0][s] - wr_cyc, 5);
        check("drop_gap", start_log[0][fb + 1] - end_log[0][fb] - 1, 3);
        repeat (2) @(negedge clk);
        check("drop_rd_pulses", rd_cnt[0] - rb, 3);

        // 17 consecutive writes: reads drop until full, then the 17th write is lost
        fb = frames[0]; rb = rd_cnt[0];
        for (int k = 0; k < 16; k++) exp_q0.push_back({2'b01, 8'(8'h30 + k), 1'b0});
        for (int k = 0; k < 17; k++) put(0, 8'(8'h30 + k));
        idle_wr(0);
        wait_frames(0, fb + 16, 1000);
        repeat (6) @(negedge clk);
        check("full_rd_pulses", rd_cnt[0] - rb, 23);
        check("full_fifo_empty", fcnt[0], 0);
        check("full_no_extra", frames[0] - fb, 16);

        // Reset during DATA bit 3 of 0xFF
        fb = frames[0]; db = done_cnt[0]; ab = aborts[0];
        put(0, 8'hFF);
        idle_wr(0);
        wr_cyc = cyc;
        while (cyc < wr_cyc + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", tx_w[0], 1);
        check("rst_mid_busy", busy_w[0], 0);
        reset = 1'b0;
        idle_bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || f_rd[0] !== 1'b0) idle_bad = 1'b1;
        end
        check("rst_stays_idle", idle_bad, 0);
        check("rst_no_done", done_cnt[0] - db, 0);
        check("rst_abort_seen", aborts[0] - ab, 1);
        check("rst_no_frame", frames[0] - fb, 0);

        exp_q0.push_back(11'b0_1_0101_1010_0);
        put(0, 8'h5A);
        idle_wr(0);
        wait_frames(0, fb + 1, 200);
        repeat (2) @(negedge clk);

        // End-of-run bookkeeping
        check("exp_q0_left", exp_q0.size(), 0);
        check("exp_q1_left", exp_q1.size(), 0);
        check("exp_q2_left", exp_q2.size(), 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("done_vs_frames[%0d]", i), done_cnt[i], frames[i]);
        end
        check("aborts_par", aborts[1] + aborts[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the 16-entry, 8-bit byte FIFO and shifts each byte out as an asynchronous UART frame. It sits directly downstream of the FIFO and connects to its `rd_en`, `dout`, `empty`, `full` and `wr_en` nets. Bytes are pulled one at a time, framed with start, optional parity and stop bits, and driven on a single `tx` line at a fixed clocks-per-bit rate.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; legal range ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2 stop bits.
- `clk` input 1: clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `fifo_empty` input 1: FIFO `empty`.
- `fifo_full` input 1: FIFO `full`.
- `fifo_wr_en` input 1: FIFO write strobe, monitored only.
- `fifo_dout` input 8: FIFO read data, registered by the FIFO on the read edge.
- `fifo_rd_en` output 1: read request to the FIFO; single-cycle pulse.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from read issue until the last stop bit completes.
- `tx_done` output 1: one-cycle pulse on the final cycle of the last stop bit.

## Operation
- States: IDLE, READ, LOAD, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx`=1, `busy`=0.
  - If `fifo_empty`=0, go to READ.
- **READ**
  - Drive `fifo_rd_en`=1 for this cycle only; `busy`=1.
  - The FIFO gives writes priority. The read is accepted iff `fifo_empty`=0 and !(`fifo_wr_en` && !`fifo_full`) in this cycle.
  - Accepted: go to LOAD.
  - Not accepted: go to IDLE with no byte consumed, then retry.
- **LOAD**
  - Capture `fifo_dout` into the shift register.
  - Compute parity: even = XOR of the data bits; odd = its inverse.
  - Go to START.
- **START**: `tx`=0 for CLKS_PER_BIT cycles.
- **DATA**
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - A 3-bit counter tracks the bit index; the shift register shifts right.
- **PARITY**
  - Only when PARITY≠0: one bit time carrying the parity bit.
  - Otherwise DATA goes directly to STOP.
- **STOP**
  - `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - `tx_done` pulses on the last cycle; then go to IDLE.
- Bit-time counter:
  - Width ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT−1 and reloads to 0 at each bit boundary.
  - Never wraps mid-bit.
- `fifo_rd_en` is never asserted outside READ. At most one read is issued per frame.

## Timing
- Reset values:
  - `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0.
  - State IDLE; counters 0; shift register 0.
- Reset mid-frame: on the next edge `tx` returns to 1 and the frame is abandoned. The byte is lost, and the FIFO is reset by the same `reset`.
- Latency from IDLE with `fifo_empty`=0 at edge N:
  - `fifo_rd_en` is high in cycle N+1.
  - `fifo_dout` is captured at the end of cycle N+2.
  - `tx` falls at the start of cycle N+3.
- Frame length: (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: after STOP the next frame adds 3 cycles of idle-high gap (IDLE, READ, LOAD) before the start bit.
- `fifo_empty` is re-sampled only in IDLE. A byte written during a frame is sent in the following frame.
- Simultaneous write and read with the FIFO not full: the read is dropped by the FIFO. This block detects it in READ and retries, with +2 cycles of gap per dropped read.
- FIFO full and `fifo_wr_en`=1 in READ: the write is ignored by the FIFO and the read proceeds.

## Test plan
- Reset while idle; CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1:
  - Required: `tx`=1, `busy`=0, `fifo_rd_en`=0 held for 10 cycles with FIFO empty.
- Write 0xA5 to the FIFO:
  - One `rd_en` pulse.
  - `tx` sequence (4 cycles each): 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses once; FIFO ends empty.
- Write 0x01,0x02,0x03 back-to-back:
  - Three frames in order, with a 3-cycle idle gap between each.
  - Exactly 3 `rd_en` pulses; `empty` at the end.
- PARITY=1 with 0x07, and PARITY=2 with 0x07:
  - The parity bit is 1 (even) and 0 (odd) respectively.
  - Frame length is 44 cycles at CLKS_PER_BIT=4.
- Force `fifo_wr_en`=1 with the FIFO not full in the READ cycle:
  - The read is dropped and retried.
  - The byte sequence is unchanged (no loss, no duplicate).
- Assert `reset` during DATA bit 3 of 0xFF:
  - `tx`=1 the next cycle, `busy`=0.
  - No `tx_done` pulse; normal operation resumes after a new write.
